eig_regime_monitor: RTL and testbench

//  Downstream consumer of the eigen core: classifies each completed result (regime, kappa, inv_kappa)
//  and runs the watchdog decision FSM with trip/clear debouncing plus a result-starvation timeout.

---
 rtl/eig_regime_monitor.sv | 225 ++++++++++++++++++++++
 tb/tb_eig_regime_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eig_regime_monitor.sv
// -----------------------------------------------------------------------------
// eig_regime_monitor
//
// Purpose:
//   Sits downstream of the eigen core. Every completed result (regime, kappa,
//   inv_kappa) is classified as good / bad / malformed. A watchdog FSM debounces
//   the bad/good stream into OK / WARN / ALARM. A starvation timer turns a long
//   silence into a stale event, which counts as one bad result.
//
// Handshake:
//   i_res_valid is a one-cycle, valid-only strobe. There is no ready. The result
//   is consumed in the same cycle if i_ena is high. If i_ena is low, the result is
//   dropped.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   i_ena            global enable; low freezes every register
//   i_res_valid      result strobe
//   i_regime         one-hot regime (001 under, 010 critical, 100 over)
//   i_kappa          signed Q16.16 oscillation term
//   i_inv_kappa      signed Q16.16 reciprocal of kappa
//   i_kappa_hi       signed threshold, sampled with i_res_valid
//   i_alarm_clr      synchronous clear request
//   o_alarm/o_warn   state decode (registered)
//   o_stale          sticky starvation flag
//   o_alarm_evt      one-cycle pulse on ALARM entry
//   o_fsm_state      00 IDLE, 01 OK, 10 WARN, 11 ALARM (debug / observability)
//   o_bad_run        consecutive-bad count, saturating at 255
//   o_fault_cnt      malformed-result count, saturating at 16'hFFFF
//   o_last_regime    regime of the last accepted result
// -----------------------------------------------------------------------------
module eig_regime_monitor #(
  parameter int W       = 32,
  parameter int TRIP_N  = 4,
  parameter int CLEAR_N = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ena,
  input  logic         i_res_valid,
  input  logic [2:0]   i_regime,
  input  logic [W-1:0] i_kappa,
  input  logic [W-1:0] i_inv_kappa,
  input  logic [W-1:0] i_kappa_hi,
  input  logic         i_alarm_clr,
  output logic         o_alarm,
  output logic         o_warn,
  output logic         o_stale,
  output logic         o_alarm_evt,
  output logic [1:0]   o_fsm_state,
  output logic [7:0]   o_bad_run,
  output logic [15:0]  o_fault_cnt,
  output logic [2:0]   o_last_regime
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GW = $clog2(CLEAR_N + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(CLEAR_N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OK    = 2'b01,
    S_WARN  = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  state_t          r_state;
  logic [7:0]      r_bad_run;
  logic [GW-1:0]   r_good_run;
  logic [TW-1:0]   r_timer;
  logic            r_stale;
  logic            r_alarm;
  logic            r_warn;
  logic            r_alarm_evt;
  logic [15:0]     r_fault_cnt;
  logic [2:0]      r_last_regime;

  logic            w_onehot;
  logic            w_malformed;
  logic            w_bad_res;
  logic            w_timeout;
  logic            w_event;
  logic            w_event_bad;
  logic [7:0]      w_bad_inc;
  state_t          w_cur;
  state_t          w_nxt_state;
  logic [7:0]      w_nxt_bad;
  logic [GW-1:0]   w_nxt_good;
  logic            w_nxt_evt;
  logic [TW-1:0]   w_nxt_timer;

  // Classification of the result presented this cycle.
  always_comb begin
    w_onehot    = (i_regime == 3'b001) || (i_regime == 3'b010) || (i_regime == 3'b100);
    // An underdamped result whose reciprocal collapsed to zero while kappa did not
    // is internally inconsistent.
    w_malformed = !w_onehot ||
                  ((i_regime == 3'b001) && (i_inv_kappa == '0) && (i_kappa != '0));
    w_bad_res   = w_malformed ||
                  ((i_regime == 3'b001) && ($signed(i_kappa) > $signed(i_kappa_hi)));
  end

  // A real result in the expiry cycle takes priority, so a timeout is only
  // raised on a silent cycle.
  always_comb begin
    w_timeout   = !i_res_valid && (r_state != S_IDLE) && (r_timer == TIMER_MAX);
    w_event     = i_res_valid || w_timeout;
    w_event_bad = w_timeout || (i_res_valid && w_bad_res);
    w_bad_inc   = (r_bad_run == 8'hFF) ? 8'hFF : r_bad_run + 8'd1;

    if (i_res_valid || (r_state == S_IDLE) || w_timeout) begin
      w_nxt_timer = '0;
    end else begin
      w_nxt_timer = r_timer + TW'(1);
    end
  end

  // Debounce transitions. The first result out of IDLE is classified as though
  // the FSM were already in OK.
  always_comb begin
    w_cur       = ((r_state == S_IDLE) && i_res_valid) ? S_OK : r_state;
    w_nxt_state = r_state;
    w_nxt_bad   = r_bad_run;
    w_nxt_good  = r_good_run;
    w_nxt_evt   = 1'b0;
    if (w_event) begin
      w_nxt_state = w_cur;
      case (w_cur)
        S_OK: begin
          if (w_event_bad) begin
            w_nxt_bad = 8'd1;
            if (TRIP_N == 1) begin
              w_nxt_state = S_ALARM;
              w_nxt_evt   = 1'b1;
            end else begin
              w_nxt_state = S_WARN;
            end
          end
        end
        S_WARN: begin
          if (w_event_bad) begin
            w_nxt_bad = w_bad_inc;
            if (int'(w_bad_inc) >= TRIP_N) begin
              w_nxt_state = S_ALARM;
              w_nxt_evt   = 1'b1;
            end
          end else begin
            w_nxt_bad   = 8'd0;
            w_nxt_state = S_OK;
          end
        end
        S_ALARM: begin
          if (w_event_bad) begin
            w_nxt_good = '0;
            w_nxt_bad  = w_bad_inc;
          end else if (r_good_run == GOOD_LAST) begin
            w_nxt_state = S_OK;
            w_nxt_good  = '0;
            w_nxt_bad   = 8'd0;
          end else begin
            w_nxt_good = r_good_run + GW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_bad_run     <= 8'd0;
      r_good_run    <= '0;
      r_timer       <= '0;
      r_stale       <= 1'b0;
      r_alarm       <= 1'b0;
      r_warn        <= 1'b0;
      r_alarm_evt   <= 1'b0;
      r_fault_cnt   <= 16'd0;
      r_last_regime <= 3'b000;
    end else if (i_ena) begin
      if (i_alarm_clr) begin
        // IDLE means nothing has been accepted yet, so a clear leaves it there.
        r_state     <= (r_state == S_IDLE) ? S_IDLE : S_OK;
        r_bad_run   <= 8'd0;
        r_good_run  <= '0;
        r_timer     <= '0;
        r_stale     <= 1'b0;
        r_alarm     <= 1'b0;
        r_warn      <= 1'b0;
        r_alarm_evt <= 1'b0;
      end else begin
        r_state     <= w_nxt_state;
        r_bad_run   <= w_nxt_bad;
        r_good_run  <= w_nxt_good;
        r_timer     <= w_nxt_timer;
        r_alarm     <= (w_nxt_state == S_ALARM);
        r_warn      <= (w_nxt_state == S_WARN);
        r_alarm_evt <= w_nxt_evt;
        if (w_timeout) begin
          r_stale <= 1'b1;
        end
        if (i_res_valid) begin
          r_last_regime <= i_regime;
          if (w_malformed && (r_fault_cnt != 16'hFFFF)) begin
            r_fault_cnt <= r_fault_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign o_alarm       = r_alarm;
  assign o_warn        = r_warn;
  assign o_stale       = r_stale;
  assign o_alarm_evt   = r_alarm_evt;
  assign o_fsm_state   = r_state;
  assign o_bad_run     = r_bad_run;
  assign o_fault_cnt   = r_fault_cnt;
  assign o_last_regime = r_last_regime;

endmodule

// File: tb/tb_eig_regime_monitor.sv
// -----------------------------------------------------------------------------
// tb_eig_regime_monitor
//   Bench for eig_regime_monitor. It applies a directed vector table, then
//   multi-cycle corner sequences, then randomized traffic. The randomized
//   traffic is compared against a small behavioural model of the watchdog.
// -----------------------------------------------------------------------------
module tb_eig_regime_monitor;

  localparam int          W       = 32;
  localparam int          TRIP_N  = 4;
  localparam int          CLEAR_N = 8;
  localparam int          TIMEOUT = 1024;
  localparam logic [31:0] HI      = 32'h0002_0000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         res_valid = 1'b0;
  logic [2:0]   regime = 3'b000;
  logic [W-1:0] kappa = '0;
  logic [W-1:0] inv_kappa = '0;
  logic [W-1:0] kappa_hi = '0;
  logic         alarm_clr = 1'b0;
  logic         alarm, warn, stale, alarm_evt;
  logic [1:0]   fsm_state;
  logic [7:0]   bad_run;
  logic [15:0]  fault_cnt;
  logic [2:0]   last_regime;

  always #5 clk = ~clk;

  eig_regime_monitor #(
    .W(W), .TRIP_N(TRIP_N), .CLEAR_N(CLEAR_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_res_valid(res_valid),
    .i_regime(regime), .i_kappa(kappa), .i_inv_kappa(inv_kappa),
    .i_kappa_hi(kappa_hi), .i_alarm_clr(alarm_clr),
    .o_alarm(alarm), .o_warn(warn), .o_stale(stale), .o_alarm_evt(alarm_evt),
    .o_fsm_state(fsm_state), .o_bad_run(bad_run), .o_fault_cnt(fault_cnt),
    .o_last_regime(last_regime)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 ok, 2 warn, 3 alarm. The quiet counter counts silent cycles
  // since the last result. The silence limit is hit on the TIMEOUT-th such cycle.
  int         m_mode, m_bad, m_good, m_quiet, m_fault;
  bit         m_stale, m_evt;
  logic [2:0] m_last;

  task automatic model_reset();
    m_mode = 0; m_bad = 0; m_good = 0; m_quiet = 0; m_fault = 0;
    m_stale = 0; m_evt = 0; m_last = 3'b000;
  endtask

  task automatic model_apply(input bit is_bad);
    if (is_bad) begin
      m_bad  = (m_bad < 255) ? m_bad + 1 : 255;
      m_good = 0;
      if (m_mode != 3 && m_bad >= TRIP_N) begin
        m_mode = 3; m_evt = 1;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end
    end else if (m_mode == 3) begin
      m_good++;
      if (m_good == CLEAR_N) begin
        m_mode = 1; m_good = 0; m_bad = 0;
      end
    end else begin
      m_mode = 1; m_bad = 0;
    end
  endtask

  task automatic model_step(input logic en, input logic rv, input logic [2:0] rg,
                            input logic [31:0] k, input logic [31:0] ik,
                            input logic [31:0] hi, input logic clr);
    bit malformed, is_bad;
    if (!en) return;
    m_evt = 0;
    if (clr) begin
      if (m_mode != 0) m_mode = 1;
      m_bad = 0; m_good = 0; m_quiet = 0; m_stale = 0;
      return;
    end
    if (rv) begin
      malformed = ($countones(rg) != 1) || (rg == 3'b001 && ik == 0 && k != 0);
      is_bad    = malformed || (rg == 3'b001 && $signed(k) > $signed(hi));
      if (malformed && m_fault < 65535) m_fault++;
      m_last  = rg;
      m_quiet = 0;
      if (m_mode == 0) m_mode = 1;
      model_apply(is_bad);
    end else if (m_mode != 0) begin
      m_quiet++;
      if (m_quiet == TIMEOUT) begin
        m_quiet = 0; m_stale = 1;
        model_apply(1'b1);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic en, input logic rv, input logic [2:0] rg,
                      input logic [31:0] k, input logic [31:0] ik,
                      input logic [31:0] hi, input logic clr);
    @(negedge clk);
    ena = en; res_valid = rv; regime = rg; kappa = k; inv_kappa = ik;
    kappa_hi = hi; alarm_clr = clr;
    @(posedge clk);
    model_step(en, rv, rg, k, ik, hi, clr);
    #1;
  endtask

  task automatic put_good();
    tick(1'b1, 1'b1, 3'b010, 32'h0, 32'h0, HI, 1'b0);
  endtask

  task automatic put_bad();
    tick(1'b1, 1'b1, 3'b001, 32'h0003_0000, 32'h0000_5555, HI, 1'b0);
  endtask

  task automatic put_idle();
    tick(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, HI, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; res_valid = 1'b0; alarm_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_const(input string nm, input logic [1:0] st, input logic [7:0] br,
                           input logic [15:0] fc, input logic stl, input logic evt);
    chk({nm, "_state"}, 32'(fsm_state), 32'(st));
    chk({nm, "_alarm"}, 32'(alarm), 32'(st == 2'b11));
    chk({nm, "_warn"},  32'(warn),  32'(st == 2'b10));
    chk({nm, "_badrun"}, 32'(bad_run), 32'(br));
    chk({nm, "_fault"}, 32'(fault_cnt), 32'(fc));
    chk({nm, "_stale"}, 32'(stale), 32'(stl));
    chk({nm, "_evt"},   32'(alarm_evt), 32'(evt));
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_state"}, 32'(fsm_state), 32'(m_mode));
    chk({nm, "_alarm"}, 32'(alarm), 32'(m_mode == 3));
    chk({nm, "_warn"},  32'(warn),  32'(m_mode == 2));
    chk({nm, "_badrun"}, 32'(bad_run), 32'(m_bad));
    chk({nm, "_fault"}, 32'(fault_cnt), 32'(m_fault));
    chk({nm, "_stale"}, 32'(stale), 32'(m_stale));
    chk({nm, "_evt"},   32'(alarm_evt), 32'(m_evt));
    chk({nm, "_last"},  32'(last_regime), 32'(m_last));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rv;
    logic [2:0]  rg;
    logic [31:0] k;
    logic [31:0] ik;
    logic        clr;
    logic [1:0]  st;
    logic [7:0]  br;
    logic [15:0] fc;
    logic        evt;
    logic [2:0]  lr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rv, input logic [2:0] rg, input logic [31:0] k,
                              input logic [31:0] ik, input logic clr, input logic [1:0] st,
                              input logic [7:0] br, input logic [15:0] fc,
                              input logic evt, input logic [2:0] lr);
    vec_t v;
    v.rv = rv; v.rg = rg; v.k = k; v.ik = ik; v.clr = clr;
    v.st = st; v.br = br; v.fc = fc; v.evt = evt; v.lr = lr;
    return v;
  endfunction

  initial begin
    // three critical results: IDLE -> OK
    vt.push_back(mk(1, 3'b010, 32'h0, 32'h0, 0, 2'd1, 8'd0, 16'd0, 0, 3'b010));
    vt.push_back(mk(1, 3'b010, 32'h0, 32'h0, 0, 2'd1, 8'd0, 16'd0, 0, 3'b010));
    vt.push_back(mk(1, 3'b010, 32'h0, 32'h0, 0, 2'd1, 8'd0, 16'd0, 0, 3'b010));
    // four over-threshold underdamped results: WARN x3 then ALARM with a pulse
    vt.push_back(mk(1, 3'b001, 32'h0003_0000, 32'h5555, 0, 2'd2, 8'd1, 16'd0, 0, 3'b001));
    vt.push_back(mk(1, 3'b001, 32'h0003_0000, 32'h5555, 0, 2'd2, 8'd2, 16'd0, 0, 3'b001));
    vt.push_back(mk(1, 3'b001, 32'h0003_0000, 32'h5555, 0, 2'd2, 8'd3, 16'd0, 0, 3'b001));
    vt.push_back(mk(1, 3'b001, 32'h0003_0000, 32'h5555, 0, 2'd3, 8'd4, 16'd0, 1, 3'b001));
    vt.push_back(mk(0, 3'b001, 32'h0003_0000, 32'h5555, 0, 2'd3, 8'd4, 16'd0, 0, 3'b001));
    // malformed: not one-hot (011, 000) and underdamped with inv=0, kappa!=0
    vt.push_back(mk(1, 3'b011, 32'h0, 32'h0, 0, 2'd3, 8'd5, 16'd1, 0, 3'b011));
    vt.push_back(mk(1, 3'b001, 32'h5, 32'h0, 0, 2'd3, 8'd6, 16'd2, 0, 3'b001));
    vt.push_back(mk(1, 3'b000, 32'h0, 32'h0, 0, 2'd3, 8'd7, 16'd3, 0, 3'b000));
    // good: kappa=0/inv=0, overdamped with big kappa, kappa == hi, negative kappa
    vt.push_back(mk(1, 3'b001, 32'h0, 32'h0, 0, 2'd3, 8'd7, 16'd3, 0, 3'b001));
    vt.push_back(mk(1, 3'b100, 32'h0003_0000, 32'h0, 0, 2'd3, 8'd7, 16'd3, 0, 3'b100));
    vt.push_back(mk(1, 3'b001, 32'h0002_0000, 32'h8000, 0, 2'd3, 8'd7, 16'd3, 0, 3'b001));
    vt.push_back(mk(1, 3'b001, 32'hFFFF_0000, 32'hFFFF_0000, 0, 2'd3, 8'd7, 16'd3, 0, 3'b001));
    // bad in ALARM: bad_run grows, no new pulse
    vt.push_back(mk(1, 3'b001, 32'h0003_0000, 32'h5555, 0, 2'd3, 8'd8, 16'd3, 0, 3'b001));
    // clear with a same-cycle result: result discarded, last_regime kept
    vt.push_back(mk(1, 3'b010, 32'h0, 32'h0, 1, 2'd1, 8'd0, 16'd3, 0, 3'b001));
    vt.push_back(mk(1, 3'b001, 32'h0003_0000, 32'h5555, 0, 2'd2, 8'd1, 16'd3, 0, 3'b001));
    vt.push_back(mk(1, 3'b010, 32'h0, 32'h0, 0, 2'd1, 8'd0, 16'd3, 0, 3'b010));
  end

  // ---------------- test sequence ----------------
  initial begin
    do_reset();
    #1;
    chk_const("reset", 2'd0, 8'd0, 16'd0, 1'b0, 1'b0);
    chk("reset_last", 32'(last_regime), 32'h0);

    // directed table
    for (int i = 0; i < vt.size(); i++) begin
      tick(1'b1, vt[i].rv, vt[i].rg, vt[i].k, vt[i].ik, HI, vt[i].clr);
      chk_const($sformatf("vec%0d", i), vt[i].st, vt[i].br, vt[i].fc, 1'b0, vt[i].evt);
      chk($sformatf("vec%0d_last", i), 32'(last_regime), 32'(vt[i].lr));
    end

    // ALARM debounce: 7 good, 1 bad, 8 good
    repeat (3) put_bad();
    put_bad();
    chk_const("t3_enter", 2'd3, 8'd4, 16'd3, 1'b0, 1'b1);
    repeat (7) put_good();
    chk_const("t3_7good", 2'd3, 8'd4, 16'd3, 1'b0, 1'b0);
    put_bad();
    chk_const("t3_bad", 2'd3, 8'd5, 16'd3, 1'b0, 1'b0);
    repeat (7) put_good();
    chk_const("t3_7good_again", 2'd3, 8'd5, 16'd3, 1'b0, 1'b0);
    put_good();
    chk_const("t3_cleared", 2'd1, 8'd0, 16'd3, 1'b0, 1'b0);

    // starvation timeout
    put_good();
    repeat (TIMEOUT - 1) put_idle();
    chk_const("t5_before", 2'd1, 8'd0, 16'd3, 1'b0, 1'b0);
    put_idle();
    chk_const("t5_expired", 2'd2, 8'd1, 16'd3, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, HI, 1'b1);
    chk_const("t5_clr", 2'd1, 8'd0, 16'd3, 1'b0, 1'b0);
    put_good();
    repeat (TIMEOUT - 1) put_idle();
    put_good();
    chk_const("t5_race", 2'd1, 8'd0, 16'd3, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) put_idle();
    chk_const("t5_restart", 2'd1, 8'd0, 16'd3, 1'b0, 1'b0);
    put_idle();
    chk_const("t5_second", 2'd2, 8'd1, 16'd3, 1'b1, 1'b0);

    // asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_const("midreset", 2'd0, 8'd0, 16'd0, 1'b0, 1'b0);
    chk("midreset_last", 32'(last_regime), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE holds the timer: long silence produces nothing
    repeat (TIMEOUT + 50) put_idle();
    chk_const("idle_quiet", 2'd0, 8'd0, 16'd0, 1'b0, 1'b0);

    // freeze under ena=0, then clear while in ALARM with a same-cycle result
    put_good();
    repeat (4) put_bad();
    repeat (TIMEOUT) put_idle();
    chk_const("t6_alarm_stale", 2'd3, 8'd5, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           32'h0003_0000, 32'h0, HI, 1'($urandom_range(0, 7) == 0));
    end
    chk_const("t6_frozen", 2'd3, 8'd5, 16'd0, 1'b1, 1'b0);
    chk("t6_frozen_last", 32'(last_regime), 32'h1);
    tick(1'b1, 1'b1, 3'b001, 32'h0003_0000, 32'h0, HI, 1'b1);
    chk_const("t6_clr", 2'd1, 8'd0, 16'd0, 1'b0, 1'b0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic        r_en, r_rv, r_clr;
      logic [2:0]  r_rg;
      logic [31:0] r_k, r_ik, r_hi;
      int          sel;
      r_en  = ($urandom_range(0, 9) != 0);
      r_rv  = ($urandom_range(0, 9) < 4);
      r_clr = ($urandom_range(0, 49) == 0);
      sel   = $urandom_range(0, 9);
      if (sel < 5)       r_rg = 3'b001;
      else if (sel == 5) r_rg = 3'b010;
      else if (sel == 6) r_rg = 3'b100;
      else               r_rg = 3'($urandom_range(0, 7));
      r_k  = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r_k = 32'hFFF0_0000 | 32'($urandom);
      if ($urandom_range(0, 9) == 0) r_k = 32'h0;
      r_ik = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      sel  = $urandom_range(0, 3);
      r_hi = (sel == 0) ? 32'h0001_0000 : (sel == 1) ? 32'hFFFF_0000 : HI;
      tick(r_en, r_rv, r_rg, r_k, r_ik, r_hi, r_clr);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
